operand_fetch: RTL and testbench

- Decode-to-execute stage in the uPOWER pipeline; sits directly upstream of the 64b x 32 register file and drives its two read addresses.
- Accepts one decoded instruction at a time, reads both source operands with the register file's 1-cycle registered read, and bypasses a same-edge writeback.
- Tracks pending destination registers in a 32-bit scoreboard and stalls RAW/WAW hazards.
- Presents a valid/ready operand bundle to the ALU.

---
 rtl/operand_fetch_pkg.sv | 13 +
 rtl/operand_fetch_scoreboard.sv | 43 ++++
 rtl/operand_fetch.sv | 139 +++++++++++++
 tb/tb_operand_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared constants and state encoding for the operand fetch stage.
package operand_fetch_pkg;
    localparam int N_DEF     = 64;             // data width per register
    localparam int R_DEF     = 32;             // architectural registers
    localparam int ASIZE_DEF = $clog2(R_DEF);  // register id width
    localparam int OPW_DEF   = 6;              // opcode field width

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2
    } of_state_e;
endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard of pending destination registers.
// A same-edge writeback to a looked-up register counts as no longer pending.
module reg_scoreboard #(
    parameter int R     = 32,
    parameter int ASIZE = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [ASIZE-1:0] set_id,
    input  logic             clr_en,
    input  logic [ASIZE-1:0] clr_id,
    input  logic [ASIZE-1:0] q_id1,
    input  logic [ASIZE-1:0] q_id2,
    input  logic [ASIZE-1:0] q_id3,
    output logic             pend1,
    output logic             pend2,
    output logic             pend3,
    output logic [R-1:0]     busy
);
    function automatic logic pend_of(input logic [R-1:0] b, input logic [ASIZE-1:0] id,
                                     input logic ce, input logic [ASIZE-1:0] cid);
        return b[id] && !(ce && cid == id);
    endfunction

    assign pend1 = pend_of(busy, q_id1, clr_en, clr_id);
    assign pend2 = pend_of(busy, q_id2, clr_en, clr_id);
    assign pend3 = pend_of(busy, q_id3, clr_en, clr_id);

    // Per-register update: a new producer beats a retiring one on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < R; i++) begin
                if (set_en && set_id == ASIZE'(i))
                    busy[i] <= 1'b1;
                else if (clr_en && clr_id == ASIZE'(i))
                    busy[i] <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch: issues register file reads, forwards a
// same-edge writeback, blocks RAW/WAW hazards and hands a bundle to the ALU.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int R     = R_DEF,
    parameter int ASIZE = $clog2(R),
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [ASIZE-1:0] dec_rs1,
    input  logic [ASIZE-1:0] dec_rs2,
    input  logic [ASIZE-1:0] dec_rd,
    input  logic             dec_rd_we,
    input  logic [OPW-1:0]   dec_op,
    input  logic [N-1:0]     dec_imm,
    output logic [ASIZE-1:0] rf_rd_id1,
    output logic [ASIZE-1:0] rf_rd_id2,
    input  logic [N-1:0]     rf_data1,
    input  logic [N-1:0]     rf_data2,
    input  logic             wb_valid,
    input  logic [ASIZE-1:0] wb_rd,
    input  logic [N-1:0]     wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OPW-1:0]   ex_op,
    output logic [N-1:0]     ex_a,
    output logic [N-1:0]     ex_b,
    output logic [N-1:0]     ex_imm,
    output logic [ASIZE-1:0] ex_rd,
    output logic             ex_rd_we
);
    of_state_e        state, state_nxt;
    logic             pend_a, pend_b, pend_d;
    logic             hazard, can_take, accept;
    logic [R-1:0]     busy;

    logic [ASIZE-1:0] lat_rs1, lat_rs2, lat_rd;
    logic             lat_rd_we;
    logic [OPW-1:0]   lat_op;
    logic [N-1:0]     lat_imm;
    logic             fwd_a, fwd_b;
    logic [N-1:0]     fwd_val;

    reg_scoreboard #(.R(R), .ASIZE(ASIZE)) u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (accept && dec_rd_we),
        .set_id (dec_rd),
        .clr_en (wb_valid),
        .clr_id (wb_rd),
        .q_id1  (dec_rs1),
        .q_id2  (dec_rs2),
        .q_id3  (dec_rd),
        .pend1  (pend_a),
        .pend2  (pend_b),
        .pend3  (pend_d),
        .busy   (busy)
    );

    assign hazard    = pend_a || pend_b || (dec_rd_we && pend_d);
    assign can_take  = (state == S_IDLE) || (state == S_OUT && ex_ready);
    assign dec_ready = can_take && !hazard && !rst;
    assign accept    = dec_valid && dec_ready;

    // The register file samples the id on the accept edge; hold it while reading.
    assign rf_rd_id1 = (state == S_READ) ? lat_rs1 : dec_rs1;
    assign rf_rd_id2 = (state == S_READ) ? lat_rs2 : dec_rs2;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: IDLE -> READ on accept, READ -> OUT, OUT drains or chains.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_READ;
            S_READ:  state_nxt = S_OUT;
            S_OUT:   if (ex_ready) state_nxt = accept ? S_READ : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the accepted instruction and any writeback landing on its sources;
    // the register file returns the pre-write value so the forward must be held.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_rs1   <= '0;
            lat_rs2   <= '0;
            lat_rd    <= '0;
            lat_rd_we <= 1'b0;
            lat_op    <= '0;
            lat_imm   <= '0;
            fwd_a     <= 1'b0;
            fwd_b     <= 1'b0;
            fwd_val   <= '0;
        end else if (accept) begin
            lat_rs1   <= dec_rs1;
            lat_rs2   <= dec_rs2;
            lat_rd    <= dec_rd;
            lat_rd_we <= dec_rd_we;
            lat_op    <= dec_op;
            lat_imm   <= dec_imm;
            fwd_a     <= wb_valid && wb_rd == dec_rs1;
            fwd_b     <= wb_valid && wb_rd == dec_rs2;
            fwd_val   <= wb_data;
        end
    end

    // Output bundle: loaded from READ, held while the ALU stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
            ex_rd_we <= 1'b0;
        end else if (state == S_READ) begin
            ex_valid <= 1'b1;
            ex_op    <= lat_op;
            ex_a     <= fwd_a ? fwd_val : rf_data1;
            ex_b     <= fwd_b ? fwd_val : rf_data2;
            ex_imm   <= lat_imm;
            ex_rd    <= lat_rd;
            ex_rd_we <= lat_rd_we;
        end else if (state == S_OUT && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 1-cycle-read register file.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int N = 64, R = 32, AW = 5, OPW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid, dec_ready, dec_rd_we;
    logic [AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [OPW-1:0] dec_op;
    logic [N-1:0]  dec_imm;
    logic [AW-1:0] rf_rd_id1, rf_rd_id2;
    logic [N-1:0]  rf_data1, rf_data2;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [N-1:0]  wb_data;
    logic          ex_valid, ex_ready, ex_rd_we;
    logic [OPW-1:0] ex_op;
    logic [N-1:0]  ex_a, ex_b, ex_imm;
    logic [AW-1:0] ex_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
        .dec_op(dec_op), .dec_imm(dec_imm),
        .rf_rd_id1(rf_rd_id1), .rf_rd_id2(rf_rd_id2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
    );

    // Register file: registered read returns the value before a same-edge write.
    logic [N-1:0] rf [R];
    always @(posedge clk) begin
        if (wb_valid) rf[wb_rd] <= wb_data;
        rf_data1 <= rf[rf_rd_id1];
        rf_data2 <= rf[rf_rd_id2];
    end

    typedef struct {
        logic [AW-1:0]  rs1, rs2, rd;
        logic           we;
        logic [OPW-1:0] op;
        logic [N-1:0]   imm;
        logic           wbv;
        logic [AW-1:0]  wbrd;
        logic [N-1:0]   wbd;
        logic [N-1:0]   ea, eb;
    } vec_t;

    function automatic vec_t mk(input logic [AW-1:0] rs1, rs2, rd, input logic we,
                                input logic [OPW-1:0] op, input logic [N-1:0] imm,
                                input logic wbv, input logic [AW-1:0] wbrd,
                                input logic [N-1:0] wbd, ea, eb);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.op = op; v.imm = imm;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        dec_valid = 1'b1; dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.rd;
        dec_rd_we = v.we; dec_op = v.op; dec_imm = v.imm;
        wb_valid = v.wbv; wb_rd = v.wbrd; wb_data = v.wbd;
    endtask

    task automatic idle_in();
        dec_valid = 1'b0; dec_rd_we = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [AW-1:0] rd, input logic [N-1:0] d);
        @(negedge clk); wb_valid = 1'b1; wb_rd = rd; wb_data = d;
        @(negedge clk); wb_valid = 1'b0;
    endtask

    // One consume cycle on the ALU side; the bundle must then be gone.
    task automatic consume(input string tag);
        ex_ready = 1'b1;
        @(negedge clk); ex_ready = 1'b0;
        #1 chk({tag, "_drop"}, 64'(ex_valid), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk); drive(v);
        #1 chk({tag, "_ready"}, 64'(dec_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); idle_in(); dec_rs1 = ~v.rs1; dec_rs2 = ~v.rs2;
        #1 chk({tag, "_read_vld"}, 64'(ex_valid), 64'd0);
        chk({tag, "_rdid1"}, 64'(rf_rd_id1), 64'(v.rs1));
        chk({tag, "_rdid2"}, 64'(rf_rd_id2), 64'(v.rs2));
        @(negedge clk);
        chk({tag, "_vld"}, 64'(ex_valid), 64'd1);
        chk({tag, "_a"},   ex_a, v.ea);
        chk({tag, "_b"},   ex_b, v.eb);
        chk({tag, "_op"},  64'(ex_op), 64'(v.op));
        chk({tag, "_imm"}, ex_imm, v.imm);
        chk({tag, "_rd"},  64'(ex_rd), 64'(v.rd));
        chk({tag, "_we"},  64'(ex_rd_we), 64'(v.we));
        consume(tag);
    endtask

    vec_t vt [7];
    vec_t tmp;

    initial begin
        for (int i = 0; i < R; i++) rf[i] = '0;
        rst = 1'b1; ex_ready = 1'b0; idle_in();
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_op = '0; dec_imm = '0;
        wb_rd = '0; wb_data = '0;

        // Reset: dec_ready low even with an offer pending.
        dec_valid = 1'b1;
        @(negedge clk); #1 chk("rst_ready", 64'(dec_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0; dec_valid = 1'b0;
        #1;
        chk("rst_vld",   64'(ex_valid), 64'd0);
        chk("rst_a",     ex_a, 64'd0);
        chk("rst_op",    64'(ex_op), 64'd0);
        chk("rst_busy",  64'(dut.busy), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(S_IDLE));
        chk("rst_ready_after", 64'(dec_ready), 64'd1);

        wb_write(5, 64'h11); wb_write(6, 64'h22); wb_write(12, 64'h5);
        wb_write(1, 64'd100); wb_write(2, 64'd200);

        //        rs1 rs2 rd we op  imm                     wbv wbrd wbd            ea             eb
        vt[0] = mk(5,  6,  7, 1, 3, 64'h1234,               0,  0,  64'h0,         64'h11,        64'h22);
        vt[1] = mk(12, 12, 13, 0, 1, 64'h0,                 0,  0,  64'h0,         64'h5,         64'h5);
        vt[2] = mk(12, 12, 14, 0, 2, 64'h0,                 1,  12, 64'h9,         64'h9,         64'h9);
        vt[3] = mk(1,  2,  15, 0, 4, 64'h8,                 1,  2,  64'h77,        64'd100,       64'h77);
        vt[4] = mk(12, 5,  16, 0, 5, 64'h0,                 0,  0,  64'h0,         64'h9,         64'h11);
        vt[5] = mk(0,  31, 0,  0, 6, 64'h0,                 1,  0,  64'hDEAD,      64'hDEAD,      64'h0);
        vt[6] = mk(31, 0,  31, 1, 63, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0,         64'h0,         64'hDEAD);
        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("v%0d", i));
        chk("busy_after_tbl", 64'(dut.busy), 64'h8000_0080);

        // RAW on r7: stalls until its writeback, which is forwarded on the accept edge.
        @(negedge clk);
        drive(mk(7, 5, 8, 0, 2, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0));
        #1 chk("raw_stall0", 64'(dec_ready), 64'd0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk); #1 chk($sformatf("raw_stall%0d", k), 64'(dec_ready), 64'd0);
        end
        @(negedge clk); wb_valid = 1'b1; wb_rd = 7; wb_data = 64'hABCD;
        #1 chk("raw_ready", 64'(dec_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); idle_in();
        @(negedge clk);
        chk("raw_vld", 64'(ex_valid), 64'd1);
        chk("raw_a", ex_a, 64'hABCD);
        chk("raw_b", ex_b, 64'h11);
        consume("raw");
        chk("raw_busy", 64'(dut.busy), 64'h8000_0000);
        wb_write(31, 64'h3131);

        // WAW on r9: set wins over the clearing writeback on the accept edge.
        run_vec(mk(5, 6, 9, 1, 4, 64'h0, 0, 0, 64'h0, 64'h11, 64'h22), "waw_prod");
        chk("waw_busy_set", 64'(dut.busy), 64'h200);
        @(negedge clk);
        drive(mk(5, 6, 9, 1, 4, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0));
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("waw_stall%0d", k), 64'(dec_ready), 64'd0);
            @(negedge clk);
        end
        wb_valid = 1'b1; wb_rd = 9; wb_data = 64'h99;
        #1 chk("waw_ready", 64'(dec_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); idle_in();
        #1 chk("waw_busy_kept", 64'(dut.busy), 64'h200);
        @(negedge clk);
        chk("waw_a", ex_a, 64'h11);
        chk("waw_rd", 64'(ex_rd), 64'd9);
        consume("waw");
        wb_write(9, 64'h99);
        chk("waw_busy_clr", 64'(dut.busy), 64'd0);

        // Backpressure: bundle held for 5 cycles, then back-to-back handoff.
        @(negedge clk);
        drive(mk(5, 6, 20, 0, 7, 64'h55, 0, 0, 64'h0, 64'h0, 64'h0));
        @(posedge clk);
        @(negedge clk); idle_in();
        @(negedge clk);
        drive(mk(12, 1, 21, 0, 9, 64'h66, 0, 0, 64'h0, 64'h0, 64'h0));
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_ready", k), 64'(dec_ready), 64'd0);
            chk($sformatf("bp%0d_vld", k), 64'(ex_valid), 64'd1);
            chk($sformatf("bp%0d_a", k), ex_a, 64'h11);
            chk($sformatf("bp%0d_b", k), ex_b, 64'h22);
            chk($sformatf("bp%0d_op", k), 64'(ex_op), 64'd7);
            @(negedge clk);
        end
        ex_ready = 1'b1;
        #1 chk("bp_b2b_ready", 64'(dec_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); ex_ready = 1'b0; idle_in();
        #1 chk("bp_gap", 64'(ex_valid), 64'd0);
        @(negedge clk);
        chk("bp2_vld", 64'(ex_valid), 64'd1);
        chk("bp2_a", ex_a, 64'h9);
        chk("bp2_b", ex_b, 64'd100);
        chk("bp2_op", 64'(ex_op), 64'd9);
        consume("bp2");

        // Reset while in READ with r3 pending.
        @(negedge clk);
        drive(mk(1, 2, 3, 1, 1, 64'h0, 0, 0, 64'h0, 64'h0, 64'h0));
        @(posedge clk);
        @(negedge clk); idle_in(); rst = 1'b1;
        #1 chk("mid_busy3", 64'(dut.busy), 64'h8);
        chk("mid_rst_ready", 64'(dec_ready), 64'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("mid_vld", 64'(ex_valid), 64'd0);
        chk("mid_busy", 64'(dut.busy), 64'd0);
        chk("mid_state", 64'(dut.state), 64'(S_IDLE));
        chk("mid_ready", 64'(dec_ready), 64'd1);
        @(negedge clk);
        chk("mid_stay_idle", 64'(ex_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
